// File: rtl/bot_nav_ctrl_pkg.sv
// Shared definitions for the Rojobot navigation controller: state encodings,
// Sensors bit positions, MotCtl field layout and the motor-word packer.
package bot_nav_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRACK_F = 3'd1,
        ST_TRACK_L = 3'd2,
        ST_TRACK_R = 3'd3,
        ST_BACKUP  = 3'd4,
        ST_TURN    = 3'd5,
        ST_STOP    = 3'd6
    } nav_state_e;

    // Line bits read 0 when the sensor is over the line.
    localparam int SNS_PROX_L = 4;
    localparam int SNS_PROX_R = 3;
    localparam int SNS_LINE_L = 2;
    localparam int SNS_LINE_C = 1;
    localparam int SNS_LINE_R = 0;

    localparam int MOT_LSPD_LSB = 5;
    localparam int MOT_LDIR     = 4;
    localparam int MOT_RSPD_LSB = 1;
    localparam int MOT_RDIR     = 0;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    function automatic logic [7:0] mot_pack(input logic [2:0] lspd, input logic ldir,
                                            input logic [2:0] rspd, input logic rdir);
        logic [7:0] m;
        m                       = 8'h00;
        m[MOT_LSPD_LSB +: 3]    = lspd;
        m[MOT_LDIR]             = ldir;
        m[MOT_RSPD_LSB +: 3]    = rspd;
        m[MOT_RDIR]             = rdir;
        return m;
    endfunction

endpackage

// File: rtl/bot_upd_edge.sv
// Turns every toggle of the world-interface update flag into a one-cycle event.
// The armed flag masks the first cycle after reset so a flag already high is not seen as a toggle.
module bot_upd_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic upd_i,
    output logic evt_o
);

    logic upd_q;
    logic armed_q;

    // Previous flag value and arming after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            upd_q   <= upd_i;
            armed_q <= 1'b1;
        end
    end

    assign evt_o = armed_q & (upd_i ^ upd_q);

endmodule

// File: rtl/bot_nav_ctrl.sv
// Line-following navigation controller: snapshots the world registers on each update
// event, makes one steering decision per event and drives MotCtl back to the world.
module bot_nav_ctrl
    import bot_nav_ctrl_pkg::*;
#(
    parameter logic [2:0]  FWD_SPD        = 3'd4,
    parameter logic [2:0]  TURN_SPD       = 3'd2,
    parameter int unsigned BACKUP_UPDATES = 4,
    parameter int unsigned LOST_LIMIT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        upd_sysregs,
    input  logic [7:0]  LocX,
    input  logic [7:0]  LocY,
    input  logic [7:0]  BotInfo,
    input  logic [7:0]  Sensors,
    output logic [7:0]  MotCtl,
    output logic [2:0]  nav_state,
    output logic        halted,
    output logic [15:0] upd_cnt
);

    localparam logic [3:0] BACKUP_INIT = 4'(BACKUP_UPDATES);
    localparam logic [7:0] LOST_MAX    = 8'(LOST_LIMIT);
    localparam logic [7:0] MOT_FWD     = mot_pack(FWD_SPD, DIR_FWD, FWD_SPD, DIR_FWD);
    localparam logic [7:0] MOT_VEER_L  = mot_pack(TURN_SPD, DIR_FWD, FWD_SPD, DIR_FWD);
    localparam logic [7:0] MOT_VEER_R  = mot_pack(FWD_SPD, DIR_FWD, TURN_SPD, DIR_FWD);
    localparam logic [7:0] MOT_BACK    = mot_pack(TURN_SPD, DIR_REV, TURN_SPD, DIR_REV);
    localparam logic [7:0] MOT_PIVOT   = mot_pack(TURN_SPD, DIR_FWD, TURN_SPD, DIR_REV);

    logic        evt_s;
    logic        eval_q;
    logic [7:0]  locx_q, locy_q, info_q, sns_q;
    logic [15:0] upd_cnt_q;

    nav_state_e  state_q, state_d;
    logic [7:0]  mot_q, mot_d;
    logic [7:0]  lost_q, lost_d;
    logic [3:0]  backup_q, backup_d;
    logic [2:0]  target_q, target_d;
    logic        halted_q, halted_d;

    nav_state_e  keep_state_s, trk_state_s;
    logic [7:0]  keep_mot_s, trk_mot_s, trk_lost_s, lost_inc_s;
    logic [3:0]  trk_backup_s;
    logic        line_seen_s;
    logic        snap_unused_s;

    bot_upd_edge u_upd_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .upd_i  (upd_sysregs),
        .evt_o  (evt_s)
    );

    // Position registers are captured for future waypoint logic and not yet steered on.
    assign snap_unused_s = ^{locx_q, locy_q, info_q[7:3], sns_q[7:5]};

    // Snapshot, event counter and the one-cycle-delayed eval strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_q    <= 1'b0;
            locx_q    <= 8'h00;
            locy_q    <= 8'h00;
            info_q    <= 8'h00;
            sns_q     <= 8'h00;
            upd_cnt_q <= 16'h0000;
        end else begin
            eval_q <= evt_s;
            if (evt_s) begin
                locx_q    <= LocX;
                locy_q    <= LocY;
                info_q    <= BotInfo;
                sns_q     <= Sensors;
                upd_cnt_q <= upd_cnt_q + 16'd1;
            end
        end
    end

    // Tracking decision on the snapshot; a finished TURN counts as straight tracking.
    always_comb begin
        keep_state_s = (state_q == ST_TURN) ? ST_TRACK_F : state_q;
        keep_mot_s   = (state_q == ST_TURN) ? MOT_FWD : mot_q;
        line_seen_s  = ~&sns_q[2:0];
        lost_inc_s   = lost_q + 8'd1;
        trk_state_s  = keep_state_s;
        trk_mot_s    = keep_mot_s;
        trk_lost_s   = line_seen_s ? 8'h00 : lost_q;
        trk_backup_s = backup_q;
        if (sns_q[SNS_PROX_L] || sns_q[SNS_PROX_R]) begin
            trk_state_s  = ST_BACKUP;
            trk_mot_s    = MOT_BACK;
            trk_backup_s = BACKUP_INIT;
        end else if (!sns_q[SNS_LINE_C]) begin
            trk_state_s = ST_TRACK_F;
            trk_mot_s   = MOT_FWD;
        end else if (!sns_q[SNS_LINE_L]) begin
            trk_state_s = ST_TRACK_L;
            trk_mot_s   = MOT_VEER_L;
        end else if (!sns_q[SNS_LINE_R]) begin
            trk_state_s = ST_TRACK_R;
            trk_mot_s   = MOT_VEER_R;
        end else if (lost_inc_s == LOST_MAX) begin
            trk_state_s = ST_STOP;
            trk_mot_s   = 8'h00;
            trk_lost_s  = lost_inc_s;
        end else begin
            trk_lost_s  = lost_inc_s;
        end
    end

    // Next-state logic; enable low overrides everything, including a pending eval.
    always_comb begin
        state_d  = state_q;
        mot_d    = mot_q;
        lost_d   = lost_q;
        backup_d = backup_q;
        target_d = target_q;
        if (!enable) begin
            state_d  = ST_IDLE;
            mot_d    = 8'h00;
            lost_d   = 8'h00;
            backup_d = 4'h0;
        end else if (eval_q) begin
            case (state_q)
                ST_IDLE, ST_TRACK_F, ST_TRACK_L, ST_TRACK_R: begin
                    state_d  = trk_state_s;
                    mot_d    = trk_mot_s;
                    lost_d   = trk_lost_s;
                    backup_d = trk_backup_s;
                end
                ST_BACKUP: begin
                    if (backup_q <= 4'd1) begin
                        backup_d = 4'h0;
                        state_d  = ST_TURN;
                        mot_d    = MOT_PIVOT;
                        target_d = info_q[2:0] + 3'd2;
                    end else begin
                        backup_d = backup_q - 4'd1;
                    end
                end
                ST_TURN: begin
                    if (info_q[2:0] == target_q) begin
                        if (trk_state_s == ST_BACKUP || trk_state_s == ST_STOP) begin
                            state_d = trk_state_s;
                        end else begin
                            state_d = ST_TRACK_F;
                        end
                        mot_d    = trk_mot_s;
                        lost_d   = trk_lost_s;
                        backup_d = trk_backup_s;
                    end else begin
                        mot_d = MOT_PIVOT;
                    end
                end
                ST_STOP: begin
                    mot_d = 8'h00;
                end
                default: begin
                    state_d = ST_IDLE;
                    mot_d   = 8'h00;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        halted_d = (state_d == ST_STOP);
    end

    // Navigation state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mot_q    <= 8'h00;
            lost_q   <= 8'h00;
            backup_q <= 4'h0;
            target_q <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mot_q    <= mot_d;
            lost_q   <= lost_d;
            backup_q <= backup_d;
            target_q <= target_d;
            halted_q <= halted_d;
        end
    end

    assign MotCtl    = mot_q;
    assign nav_state = state_q;
    assign halted    = halted_q;
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_bot_nav_ctrl.sv
// Scoreboard bench for bot_nav_ctrl: stimulus pushes hand-computed expectations tagged
// with the cycle they are due, a negedge monitor pops and compares them.
module tb_bot_nav_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        upd_sysregs = 1'b1;
    logic [7:0]  LocX = 8'h10;
    logic [7:0]  LocY = 8'h20;
    logic [7:0]  BotInfo = 8'h00;
    logic [7:0]  Sensors = 8'h07;
    logic [7:0]  MotCtl;
    logic [2:0]  nav_state;
    logic        halted;
    logic [15:0] upd_cnt;

    typedef struct {
        int          due;
        logic [7:0]  mot;
        logic [2:0]  st;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0000;

    localparam logic [2:0] S_IDLE = 3'd0, S_F = 3'd1, S_L = 3'd2, S_R = 3'd3,
                           S_BK = 3'd4, S_TURN = 3'd5, S_STOP = 3'd6;

    bot_nav_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .upd_sysregs (upd_sysregs),
        .LocX        (LocX),
        .LocY        (LocY),
        .BotInfo     (BotInfo),
        .Sensors     (Sensors),
        .MotCtl      (MotCtl),
        .nav_state   (nav_state),
        .halted      (halted),
        .upd_cnt     (upd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int due, input logic [7:0] mot, input logic [2:0] st,
                        input logic halt, input logic [15:0] cnt);
        exp_t e;
        e.due = due; e.mot = mot; e.st = st; e.halt = halt; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due at this sample point.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk("stale_entry", 16'(cyc), 16'(e.due));
            end else begin
                chk("MotCtl", {8'h00, MotCtl}, {8'h00, e.mot});
                chk("nav_state", {13'h0, nav_state}, {13'h0, e.st});
                chk("halted", {15'h0, halted}, {15'h0, e.halt});
                chk("upd_cnt", upd_cnt, e.cnt);
            end
        end
    end

    // One update event; expected response due two clocks after the toggle.
    task automatic ev(input logic [7:0] sens, input logic [7:0] info,
                      input logic [7:0] mot, input logic [2:0] st, input logic halt);
        @(negedge clk);
        Sensors     = sens;
        BotInfo     = info;
        upd_sysregs = ~upd_sysregs;
        exp_cnt     = exp_cnt + 16'd1;
        push(cyc + 2, mot, st, halt, exp_cnt);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        // Reset release with the update flag already high: no event.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push(cyc + 1, 8'h00, S_IDLE, 1'b0, 16'h0000);
        push(cyc + 2, 8'h00, S_IDLE, 1'b0, 16'h0000);
        push(cyc + 3, 8'h00, S_IDLE, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);

        enable = 1'b1;
        ev(8'h05, 8'h00, 8'h99, S_F, 1'b0);

        // Obstacle: backup for four events, then pivot to orientation 7+2 = 1.
        ev(8'h15, 8'h07, 8'h44, S_BK, 1'b0);
        for (int i = 0; i < 3; i++) ev(8'h05, 8'h07, 8'h44, S_BK, 1'b0);
        ev(8'h05, 8'h07, 8'h54, S_TURN, 1'b0);
        ev(8'h05, 8'h00, 8'h54, S_TURN, 1'b0);
        ev(8'h05, 8'h01, 8'h99, S_F, 1'b0);

        // Line lost 14 times, seen at event 15, then lost 16 times -> STOP.
        for (int i = 0; i < 14; i++) ev(8'h07, 8'h01, 8'h99, S_F, 1'b0);
        ev(8'h05, 8'h01, 8'h99, S_F, 1'b0);
        for (int i = 0; i < 15; i++) ev(8'h07, 8'h01, 8'h99, S_F, 1'b0);
        ev(8'h07, 8'h01, 8'h00, S_STOP, 1'b1);
        ev(8'h05, 8'h01, 8'h00, S_STOP, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        push(cyc + 1, 8'h00, S_IDLE, 1'b0, exp_cnt);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;

        // Steering priorities from IDLE.
        ev(8'h03, 8'h01, 8'h59, S_L, 1'b0);
        ev(8'h06, 8'h01, 8'h95, S_R, 1'b0);
        ev(8'h00, 8'h01, 8'h99, S_F, 1'b0);
        ev(8'h02, 8'h01, 8'h59, S_L, 1'b0);

        // Enable drops in the eval cycle.
        @(negedge clk);
        Sensors     = 8'h05;
        upd_sysregs = ~upd_sysregs;
        exp_cnt     = exp_cnt + 16'd1;
        push(cyc + 2, 8'h00, S_IDLE, 1'b0, exp_cnt);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b1;

        // Into TURN via right proximity, then asynchronous reset.
        ev(8'h0D, 8'h00, 8'h44, S_BK, 1'b0);
        for (int i = 0; i < 3; i++) ev(8'h07, 8'h00, 8'h44, S_BK, 1'b0);
        ev(8'h07, 8'h00, 8'h54, S_TURN, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_MotCtl", {8'h00, MotCtl}, 16'h0000);
        chk("async_rst_state", {13'h0, nav_state}, 16'h0000);
        chk("async_rst_halted", {15'h0, halted}, 16'h0000);
        chk("async_rst_upd_cnt", upd_cnt, 16'h0000);
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 16'h0000;
        push(cyc + 2, 8'h00, S_IDLE, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);

        // Toggles on consecutive clocks.
        @(negedge clk);
        c0 = cyc;
        Sensors = 8'h05; upd_sysregs = ~upd_sysregs;
        push(c0 + 2, 8'h99, S_F, 1'b0, 16'd2);
        @(negedge clk);
        Sensors = 8'h03; upd_sysregs = ~upd_sysregs;
        push(c0 + 3, 8'h59, S_L, 1'b0, 16'd3);
        @(negedge clk);
        Sensors = 8'h06; upd_sysregs = ~upd_sysregs;
        push(c0 + 4, 8'h95, S_R, 1'b0, 16'd3);
        exp_cnt = 16'd3;
        repeat (3) @(negedge clk);

        // Counter wrap with navigation disabled.
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 65533; i++) begin
            @(negedge clk);
            upd_sysregs = ~upd_sysregs;
            exp_cnt     = exp_cnt + 16'd1;
            if (exp_cnt == 16'hFFFF || exp_cnt == 16'h0000)
                push(cyc + 1, 8'h00, S_IDLE, 1'b0, exp_cnt);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("scoreboard_drain", 16'(sb.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
